// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, canned results, divider state encoding, operand classifier.
// Pure declarations, no logic of its own.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } fp_state_e;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Denormals (exponent field 0) are treated as zero throughout the FPU.
    function automatic fp_class_t fp_classify_f(input logic [EXP_W+MANT_W-1:0] mag);
        fp_class_t c;
        c.is_zero = (mag[EXP_W+MANT_W-1:MANT_W] == '0);
        c.is_inf  = (mag[EXP_W+MANT_W-1:MANT_W] == '1) && (mag[MANT_W-1:0] == '0);
        c.is_nan  = (mag[EXP_W+MANT_W-1:MANT_W] == '1) && (mag[MANT_W-1:0] != '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 operand classifier (sign excluded); zero latency, no handshake.
// Exponent 0 reports zero regardless of mantissa; exponent all-ones splits into Inf / NaN.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [30:0] i_mag,
    output logic        o_is_zero,
    output logic        o_is_inf,
    output logic        o_is_nan
);

    fp_class_t w_cls;

    assign w_cls     = fp_classify_f(i_mag);
    assign o_is_zero = w_cls.is_zero;
    assign o_is_inf  = w_cls.is_inf;
    assign o_is_nan  = w_cls.is_nan;

endmodule

// File: rtl/fp_divider.sv
// Sequential binary32 divider (restoring, 1 quotient bit/cycle, RNE); result 28 edges after accept, specials 1 edge.
// One op in flight: in_ready low until the output handshake; result held while out_ready is low. Option: FPDIV_FLAGS_EN.
module fp_divider #(
    parameter int QBITS    = 26,
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
`ifdef FPDIV_FLAGS_EN
    ,
    output logic [4:0]  flags
`endif
);
    import fpu_pkg::*;

    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_DIVIDE = S_DIVIDE;
    localparam logic [1:0] ST_ROUND  = S_ROUND;
    localparam logic [1:0] ST_DONE   = S_DONE;
    localparam logic [4:0] CNT_LAST  = 5'(QBITS - 1);

    logic [1:0]        r_state;
    logic [24:0]       r_rem;
    logic [23:0]       r_div;
    logic [QBITS-1:0]  r_quo;
    logic [4:0]        r_cnt;
    logic signed [9:0] r_exp;
    logic              r_sign;
    logic [31:0]       r_result;
    logic              r_out_valid;

    logic w_a_zero, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_inf, w_b_nan;

    fp_classify u_cls_a (.i_mag(a[30:0]), .o_is_zero(w_a_zero), .o_is_inf(w_a_inf), .o_is_nan(w_a_nan));
    fp_classify u_cls_b (.i_mag(b[30:0]), .o_is_zero(w_b_zero), .o_is_inf(w_b_inf), .o_is_nan(w_b_nan));

    logic              w_sign;
    logic              w_special;
    logic [31:0]       w_spec_res;
    logic signed [9:0] w_exp_init;
`ifdef FPDIV_FLAGS_EN
    logic [4:0]        w_spec_flags;
    logic [4:0]        r_flags;
`endif

    assign w_sign     = a[31] ^ b[31];
    assign w_exp_init = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + $signed(10'(EXP_BIAS));

    // Flags are {invalid, div_by_zero, overflow, underflow, inexact}.
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = QNAN;
`ifdef FPDIV_FLAGS_EN
        w_spec_flags = 5'b10000;
`endif
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res = QNAN;
        end else if (w_b_zero) begin
            w_spec_res = POS_INF | {w_sign, 31'd0};
`ifdef FPDIV_FLAGS_EN
            w_spec_flags = 5'b01000;
`endif
        end else if (w_a_inf) begin
            w_spec_res = POS_INF | {w_sign, 31'd0};
`ifdef FPDIV_FLAGS_EN
            w_spec_flags = 5'b00000;
`endif
        end else if (w_b_inf || w_a_zero) begin
            w_spec_res = {w_sign, 31'd0};
`ifdef FPDIV_FLAGS_EN
            w_spec_flags = 5'b00000;
`endif
        end else begin
            w_special  = 1'b0;
            w_spec_res = 32'd0;
`ifdef FPDIV_FLAGS_EN
            w_spec_flags = 5'b00000;
`endif
        end
    end

    // One restoring step; the partial remainder is always below the divisor after subtraction.
    logic        w_ge;
    logic [23:0] w_rem_sub;
    logic [24:0] w_rem_next;

    assign w_ge       = (r_rem >= {1'b0, r_div});
    assign w_rem_sub  = w_ge ? 24'(r_rem - {1'b0, r_div}) : r_rem[23:0];
    assign w_rem_next = {w_rem_sub, 1'b0};

    logic              w_norm, w_guard, w_sticky, w_rnd_up, w_ovf, w_unf;
    logic [22:0]       w_frac;
    logic [23:0]       w_frac_sum;
    logic signed [9:0] w_exp_n, w_exp_r;
    logic [31:0]       w_rnd_res;

    always_comb begin
        w_norm     = r_quo[QBITS-1];
        w_frac     = w_norm ? r_quo[QBITS-2:2] : r_quo[QBITS-3:1];
        w_guard    = w_norm ? r_quo[1] : r_quo[0];
        w_sticky   = (r_rem != '0) || (w_norm && r_quo[0]);
        w_exp_n    = w_norm ? r_exp : r_exp - 10'sd1;
        w_rnd_up   = w_guard && (w_sticky || w_frac[0]);
        w_frac_sum = {1'b0, w_frac} + {23'd0, w_rnd_up};
        w_exp_r    = w_frac_sum[23] ? w_exp_n + 10'sd1 : w_exp_n;
        w_ovf      = (w_exp_r >= 10'sd255);
        w_unf      = (w_exp_r <= 10'sd0);
        if (w_ovf) begin
            w_rnd_res = POS_INF | {r_sign, 31'd0};
        end else if (w_unf) begin
            w_rnd_res = {r_sign, 31'd0};
        end else begin
            w_rnd_res = {r_sign, w_exp_r[7:0], w_frac_sum[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_div       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_result    <= 32'd0;
            r_out_valid <= 1'b0;
`ifdef FPDIV_FLAGS_EN
            r_flags     <= 5'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_result <= w_spec_res;
`ifdef FPDIV_FLAGS_EN
                            r_flags  <= w_spec_flags;
`endif
                            r_state  <= ST_DONE;
                        end else begin
                            r_rem   <= {2'b01, a[22:0]};
                            r_div   <= {1'b1, b[22:0]};
                            r_quo   <= '0;
                            r_cnt   <= '0;
                            r_exp   <= w_exp_init;
                            r_state <= ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[QBITS-2:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_result <= w_rnd_res;
`ifdef FPDIV_FLAGS_EN
                    r_flags  <= {2'b00, w_ovf, w_unf, w_ovf || w_unf || w_guard || w_sticky};
`endif
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // out_valid trails entry into DONE by one edge and drops on the handshake edge.
            r_out_valid <= (r_state == ST_DONE) && !(r_out_valid && out_ready);
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
`ifdef FPDIV_FLAGS_EN
    assign flags     = r_flags;
`endif

endmodule
